// File: rtl/pipe_skid_reg_pkg.sv
// Shared constants for the elastic pipeline stage registers.
// Holds the per-stage field widths, the control-bit layout and the state encoding.
package pipe_skid_reg_pkg;

   // Per-stage field widths.
   localparam int IF_ID_CTRL_WIDTH  = 1;
   localparam int IF_ID_DATA_WIDTH  = 64;
   localparam int ID_EX_CTRL_WIDTH  = 12;
   localparam int ID_EX_DATA_WIDTH  = 136;
   localparam int EX_MEM_CTRL_WIDTH = 3;
   localparam int EX_MEM_DATA_WIDTH = 72;
   localparam int MEM_WB_CTRL_WIDTH = 2;
   localparam int MEM_WB_DATA_WIDTH = 37;

   // Control-bit positions used to pack and unpack the ID/EX control field.
   localparam int CTRL_MEM_R_EN  = 0;
   localparam int CTRL_MEM_W_EN  = 1;
   localparam int CTRL_WB_EN     = 2;
   localparam int CTRL_B         = 3;
   localparam int CTRL_S         = 4;
   localparam int CTRL_IMM       = 5;
   localparam int CTRL_EX_CMD_LO = 6;
   localparam int CTRL_EX_CMD_HI = 9;

   // State is simply {skid.valid, main.valid}; 2'b10 cannot occur.
   typedef enum logic [1:0] {
      S0 = 2'b00,   // empty
      S1 = 2'b01,   // main only
      S2 = 2'b11    // main + skid
   } skid_state_e;

   // Number of valid entries held in a given state.
   function automatic logic [1:0] occ_of(skid_state_e s);
      case (s)
         S0:      occ_of = 2'd0;
         S1:      occ_of = 2'd1;
         S2:      occ_of = 2'd2;
         default: occ_of = 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/pipe_skid_reg_entry.sv
// One storage slot of the skid register: valid + ctrl (cleared on reset/clear)
// and data (only ever written by a load, so it survives reset and flush).
module pipe_entry #(
   parameter int CTRL_WIDTH = 12,
   parameter int DATA_WIDTH = 136
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic                  clear,
   input  logic [CTRL_WIDTH-1:0] d_ctrl,
   input  logic [DATA_WIDTH-1:0] d_data,
   output logic                  valid,
   output logic [CTRL_WIDTH-1:0] ctrl,
   output logic [DATA_WIDTH-1:0] data
);

   // Valid and ctrl: reset > clear > load > hold.
   always_ff @(posedge clk) begin
      if (!rst) begin
         valid <= 1'b0;
         ctrl  <= '0;
      end else if (clear) begin
         valid <= 1'b0;
         ctrl  <= '0;
      end else if (load) begin
         valid <= 1'b1;
         ctrl  <= d_ctrl;
      end
   end

   // Data has no reset; it moves only on a real load.
   always_ff @(posedge clk) begin
      if (rst && load && !clear)
         data <= d_data;
   end

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry elastic pipeline register with flush. The skid entry absorbs the
// one entry that may arrive in the cycle out_ready falls, so in_ready can be a
// flop with no combinational path from downstream.
module pipe_skid_reg
   import pipe_skid_reg_pkg::*;
#(
   parameter int CTRL_WIDTH = 12,
   parameter int DATA_WIDTH = 136
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [CTRL_WIDTH-1:0] in_ctrl,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [CTRL_WIDTH-1:0] out_ctrl,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [1:0]            occupancy
);

   logic                  main_valid, skid_valid;
   logic [CTRL_WIDTH-1:0] main_ctrl,  skid_ctrl;
   logic [DATA_WIDTH-1:0] main_data,  skid_data;

   logic                  main_load, main_clear, main_from_skid;
   logic                  skid_load, skid_clear;
   logic [CTRL_WIDTH-1:0] main_d_ctrl;
   logic [DATA_WIDTH-1:0] main_d_data;

   logic                  accept, consume;
   skid_state_e           state, state_nxt;

   assign state   = skid_state_e'({skid_valid, main_valid});
   assign accept  = in_valid && in_ready;
   assign consume = main_valid && out_ready;

   // Main refills from skid when draining S2, otherwise from the input.
   assign main_d_ctrl = main_from_skid ? skid_ctrl : in_ctrl;
   assign main_d_data = main_from_skid ? skid_data : in_data;

   // Next state and per-entry load/clear strobes; flush overrides the handshake.
   always_comb begin
      main_load      = 1'b0;
      main_clear     = 1'b0;
      main_from_skid = 1'b0;
      skid_load      = 1'b0;
      skid_clear     = 1'b0;
      state_nxt      = state;
      if (flush) begin
         main_clear = 1'b1;
         skid_clear = 1'b1;
         state_nxt  = S0;
      end else begin
         case (state)
            S0: begin
               if (accept) begin
                  main_load = 1'b1;
                  state_nxt = S1;
               end
            end
            S1: begin
               if (accept && consume) begin
                  main_load = 1'b1;
               end else if (accept) begin
                  skid_load = 1'b1;
                  state_nxt = S2;
               end else if (consume) begin
                  main_clear = 1'b1;
                  state_nxt  = S0;
               end
            end
            S2: begin
               // in_ready is low here, so no accept can coincide.
               if (consume) begin
                  main_load      = 1'b1;
                  main_from_skid = 1'b1;
                  skid_clear     = 1'b1;
                  state_nxt      = S1;
               end
            end
            default: begin
               // Skid-only is unreachable; recover to empty.
               main_clear = 1'b1;
               skid_clear = 1'b1;
               state_nxt  = S0;
            end
         endcase
      end
   end

   pipe_entry #(.CTRL_WIDTH(CTRL_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_main (
      .clk    (clk),
      .rst    (rst),
      .load   (main_load),
      .clear  (main_clear),
      .d_ctrl (main_d_ctrl),
      .d_data (main_d_data),
      .valid  (main_valid),
      .ctrl   (main_ctrl),
      .data   (main_data)
   );

   pipe_entry #(.CTRL_WIDTH(CTRL_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_skid (
      .clk    (clk),
      .rst    (rst),
      .load   (skid_load),
      .clear  (skid_clear),
      .d_ctrl (in_ctrl),
      .d_data (in_data),
      .valid  (skid_valid),
      .ctrl   (skid_ctrl),
      .data   (skid_data)
   );

   // in_ready and occupancy are registered copies of the next state.
   always_ff @(posedge clk) begin
      if (!rst) begin
         in_ready  <= 1'b1;
         occupancy <= 2'd0;
      end else begin
         in_ready  <= (state_nxt != S2);
         occupancy <= occ_of(state_nxt);
      end
   end

   assign out_valid = main_valid;
   assign out_ctrl  = main_ctrl;
   assign out_data  = main_data;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed vector table, reset/flush corners and a
// random run against a reference queue, over three width configurations.
module tb_pipe_skid_reg;

   localparam int CW = 12;
   localparam int DW = 136;

   logic          clk = 1'b0;
   logic          rst, flush, in_valid, out_ready;
   logic [CW-1:0] in_ctrl;
   logic [DW-1:0] in_data;

   logic          in_ready, out_valid;
   logic [CW-1:0] out_ctrl;
   logic [DW-1:0] out_data;
   logic [1:0]    occupancy;

   logic          b_in_ready, b_out_valid;
   logic [0:0]    b_out_ctrl;
   logic [255:0]  b_out_data;
   logic [1:0]    b_occupancy;

   logic          c_in_ready, c_out_valid;
   logic [0:0]    c_out_ctrl;
   logic [0:0]    c_out_data;
   logic [1:0]    c_occupancy;

   always #5 clk = ~clk;

   pipe_skid_reg #(.CTRL_WIDTH(CW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_ctrl(out_ctrl), .out_data(out_data), .occupancy(occupancy));

   pipe_skid_reg #(.CTRL_WIDTH(1), .DATA_WIDTH(256)) dut_b (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
      .in_ctrl(in_ctrl[0]), .in_data({120'b0, in_data}), .out_valid(b_out_valid),
      .out_ready(out_ready), .out_ctrl(b_out_ctrl), .out_data(b_out_data),
      .occupancy(b_occupancy));

   pipe_skid_reg #(.CTRL_WIDTH(1), .DATA_WIDTH(1)) dut_c (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(c_in_ready),
      .in_ctrl(in_ctrl[0]), .in_data(in_data[0]), .out_valid(c_out_valid),
      .out_ready(out_ready), .out_ctrl(c_out_ctrl), .out_data(c_out_data),
      .occupancy(c_occupancy));

   typedef struct {
      logic          iv, fl, ordy;
      logic [CW-1:0] c;
      logic          ov;
      logic [CW-1:0] oc;
      logic [1:0]    occ;
      logic          ir;
   } vec_t;

   typedef struct {
      logic [CW-1:0] c;
      logic [DW-1:0] d;
   } ent_t;

   ent_t sb[$];
   vec_t tbl[18];
   int   checks   = 0;
   int   failures = 0;

   function automatic vec_t mk(logic iv, logic fl, logic ordy, logic [CW-1:0] c,
                               logic ov, logic [CW-1:0] oc, logic [1:0] occ, logic ir);
      vec_t v;
      v.iv = iv; v.fl = fl; v.ordy = ordy; v.c = c;
      v.ov = ov; v.oc = oc; v.occ = occ; v.ir = ir;
      return v;
   endfunction

   function automatic logic [DW-1:0] dat(logic [CW-1:0] c);
      return {c, 100'h0, ~c, 12'hA5A};
   endfunction

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   // Compare all three DUTs against the reference queue.
   task automatic check_state();
      logic          v;
      logic [CW-1:0] ec;
      logic [DW-1:0] ed;
      v  = (sb.size() > 0);
      ec = '0;
      ed = '0;
      if (v) begin
         ec = sb[0].c;
         ed = sb[0].d;
      end
      chk("out_valid", 256'(out_valid), 256'(v));
      chk("occupancy", 256'(occupancy), 256'(sb.size()));
      chk("in_ready",  256'(in_ready),  256'(sb.size() < 2));
      chk("out_ctrl",  256'(out_ctrl),  256'(ec));
      if (v) chk("out_data", 256'(out_data), 256'(ed));
      chk("b_out_valid", 256'(b_out_valid), 256'(v));
      chk("b_occupancy", 256'(b_occupancy), 256'(sb.size()));
      chk("b_in_ready",  256'(b_in_ready),  256'(sb.size() < 2));
      chk("b_out_ctrl",  256'(b_out_ctrl),  256'(ec[0]));
      if (v) chk("b_out_data", b_out_data, {120'b0, ed});
      chk("c_out_valid", 256'(c_out_valid), 256'(v));
      chk("c_occupancy", 256'(c_occupancy), 256'(sb.size()));
      chk("c_in_ready",  256'(c_in_ready),  256'(sb.size() < 2));
      chk("c_out_ctrl",  256'(c_out_ctrl),  256'(ec[0]));
      if (v) chk("c_out_data", 256'(c_out_data), 256'(ed[0]));
   endtask

   // Drive one cycle, update the reference queue at the edge, then check.
   task automatic step(input logic r, input logic fl, input logic iv, input logic ordy,
                       input logic [CW-1:0] c, input logic [DW-1:0] d);
      logic acc, cons;
      rst = r; flush = fl; in_valid = iv; out_ready = ordy; in_ctrl = c; in_data = d;
      acc  = iv && (sb.size() < 2);
      cons = ordy && (sb.size() > 0);
      if (cons && r) begin
         chk("sb_ctrl", 256'(out_ctrl), 256'(sb[0].c));
         chk("sb_data", 256'(out_data), 256'(sb[0].d));
      end
      @(posedge clk);
      if (!r || fl) begin
         sb.delete();
      end else begin
         if (cons) void'(sb.pop_front());
         if (acc) sb.push_back('{c: c, d: d});
      end
      #1;
      check_state();
   endtask

   initial begin
      logic [CW-1:0] rc;
      logic [DW-1:0] rd;
      logic [DW-1:0] held;

      // stream 0x001..0x005
      tbl[0]  = mk(1, 0, 1, 12'h001, 1, 12'h001, 2'd1, 1);
      tbl[1]  = mk(1, 0, 1, 12'h002, 1, 12'h002, 2'd1, 1);
      tbl[2]  = mk(1, 0, 1, 12'h003, 1, 12'h003, 2'd1, 1);
      tbl[3]  = mk(1, 0, 1, 12'h004, 1, 12'h004, 2'd1, 1);
      tbl[4]  = mk(1, 0, 1, 12'h005, 1, 12'h005, 2'd1, 1);
      tbl[5]  = mk(0, 0, 1, 12'h000, 0, 12'h000, 2'd0, 1);
      // backpressure then release
      tbl[6]  = mk(1, 0, 0, 12'h011, 1, 12'h011, 2'd1, 1);
      tbl[7]  = mk(1, 0, 0, 12'h012, 1, 12'h011, 2'd2, 0);
      tbl[8]  = mk(1, 0, 0, 12'h013, 1, 12'h011, 2'd2, 0);
      tbl[9]  = mk(1, 0, 1, 12'h013, 1, 12'h012, 2'd1, 1);
      tbl[10] = mk(1, 0, 1, 12'h013, 1, 12'h013, 2'd1, 1);
      tbl[11] = mk(0, 0, 1, 12'h000, 0, 12'h000, 2'd0, 1);
      // flush in S2 with an offered entry
      tbl[12] = mk(1, 0, 0, 12'h021, 1, 12'h021, 2'd1, 1);
      tbl[13] = mk(1, 0, 0, 12'h022, 1, 12'h021, 2'd2, 0);
      tbl[14] = mk(1, 1, 0, 12'h023, 0, 12'h000, 2'd0, 1);
      tbl[15] = mk(0, 0, 1, 12'h000, 0, 12'h000, 2'd0, 1);
      // flush in S1 with accept and consume
      tbl[16] = mk(1, 0, 1, 12'h031, 1, 12'h031, 2'd1, 1);
      tbl[17] = mk(1, 1, 1, 12'h032, 0, 12'h000, 2'd0, 1);

      rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_ctrl = '0; in_data = '0;

      step(0, 0, 0, 0, '0, '0);
      step(0, 0, 0, 0, '0, '0);
      chk("rst_in_ready",  256'(in_ready),  256'(1));
      chk("rst_out_valid", 256'(out_valid), 256'(0));
      chk("rst_out_ctrl",  256'(out_ctrl),  256'(0));
      chk("rst_occupancy", 256'(occupancy), 256'(0));

      for (int i = 0; i < 18; i++) begin
         step(1, tbl[i].fl, tbl[i].iv, tbl[i].ordy, tbl[i].c, dat(tbl[i].c));
         chk($sformatf("tbl%0d_out_valid", i), 256'(out_valid), 256'(tbl[i].ov));
         chk($sformatf("tbl%0d_out_ctrl", i),  256'(out_ctrl),  256'(tbl[i].oc));
         chk($sformatf("tbl%0d_occupancy", i), 256'(occupancy), 256'(tbl[i].occ));
         chk($sformatf("tbl%0d_in_ready", i),  256'(in_ready),  256'(tbl[i].ir));
         if (tbl[i].ov)
            chk($sformatf("tbl%0d_out_data", i), 256'(out_data), 256'(dat(tbl[i].oc)));
      end

      // reset + flush together while stalled in S2: data must be held
      step(1, 0, 1, 0, 12'h041, dat(12'h041));
      step(1, 0, 1, 0, 12'h042, dat(12'h042));
      held = dat(12'h041);
      step(0, 1, 1, 0, 12'h043, dat(12'h043));
      chk("rf_in_ready",  256'(in_ready),  256'(1));
      chk("rf_out_valid", 256'(out_valid), 256'(0));
      chk("rf_out_ctrl",  256'(out_ctrl),  256'(0));
      chk("rf_occupancy", 256'(occupancy), 256'(0));
      chk("rf_out_data",  256'(out_data),  256'(held));
      chk("rf_b_out_data", b_out_data, {120'b0, held});
      step(1, 0, 0, 1, '0, '0);

      // random traffic against the reference queue
      for (int n = 0; n < 10000; n++) begin
         rc = 12'($urandom);
         rd = {$urandom, $urandom, $urandom, $urandom, 8'($urandom)};
         step(($urandom_range(0, 499) != 0),
              ($urandom_range(0, 31) == 0),
              ($urandom_range(0, 9) < 7),
              ($urandom_range(0, 9) < 6),
              rc, rd);
         if (!out_valid) chk("rnd_bubble_ctrl", 256'(out_ctrl), 256'(0));
         chk("rnd_occ_max", 256'(occupancy <= 2'd2), 256'(1));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipe_skid_reg.md
# pipe_skid_reg

Parametrised two-entry elastic pipeline register that replaces fixed, flush-only stage registers between processor pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). It adds a valid/ready handshake so a stage can stall without combinational ready paths crossing the boundary, and provides a flush that turns the stage into a bubble. Each entry carries a control field, zeroed on flush/reset, and a data field, held on flush/reset. Each pipeline stage boundary instantiates one copy, with widths set per stage.

## Interface

Parameters:
- `CTRL_WIDTH`, default 12: width of the control field (MEM_R_EN, MEM_W_EN, WB_EN, B, S, Imm, EX_CMD, …). Zeroed on reset and flush.
- `DATA_WIDTH`, default 136: width of the data field (PC, operand values, immediates, dest, status). Held on reset and flush.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `flush`  in  1  discard both entries this cycle.
- `in_valid`  in  1  upstream offers an entry.
- `in_ready`  out  1  block can accept; registered output.
- `in_ctrl`  in  CTRL_WIDTH  control field of the offered entry.
- `in_data`  in  DATA_WIDTH  data field of the offered entry.
- `out_valid`  out  1  main entry is valid.
- `out_ready`  in  1  downstream consumes the main entry when asserted with `out_valid`.
- `out_ctrl`  out  CTRL_WIDTH  control field of the main entry; 0 whenever `out_valid`=0.
- `out_data`  out  DATA_WIDTH  data field of the main entry.
- `occupancy`  out  2  number of valid entries, 0..2.

## Operation

- Storage: main entry (drives `out_*`) and skid entry, each holding valid, ctrl and data.
- Accept: `in_valid && in_ready`. Consume: `out_valid && out_ready`.
- `in_ready` = NOT skid.valid, registered.
- Priority, highest first:
  - reset;
  - flush;
  - the normal update.
- Normal update, by state (S0 = empty, S1 = main only, S2 = main + skid):
  - S0, accept → S1; main ← input.
  - S1, accept and consume → S1; main ← input.
  - S1, accept and no consume → S2; skid ← input.
  - S1, consume and no accept → S0.
  - S2, consume → S1; main ← skid; skid cleared. No accept is possible in S2.
  - Otherwise: hold.
- Reset (`rst`=0 at a clock edge):
  - both valids ← 0 and both ctrl ← 0;
  - data is not reset;
  - `in_ready` ← 1, `occupancy` ← 0.
- Flush:
  - both valids ← 0 and both ctrl ← 0; data held;
  - an entry accepted in the flush cycle is discarded;
  - next state S0, `in_ready` = 1 next cycle.
- A consume in the flush cycle still counts on the downstream side: the main entry was presented and taken. The block takes no further action for it.
- Ordering is strictly FIFO; no entry is duplicated or lost except by flush.
- `out_ctrl` is a zero bubble whenever `out_valid`=0, so downstream enables never assert spuriously.

## Timing

- Latency: accept in cycle N → `out_valid`=1 with that entry in cycle N+1, when the block was in S0, or in S1 with a consume in cycle N.
- Throughput: 1 entry per cycle while `out_ready` stays 1.
- `out_ready` falling costs nothing: the entry accepted in the same cycle lands in skid, and `in_ready` drops the following cycle.
- `out_ready` rising from S2: main is refilled from skid in the next cycle; `in_ready` returns to 1 that same next cycle.
- No combinational path from `out_ready` to `in_ready`, nor from any input to any output. All outputs are flops.
- Reset values of all outputs:
  - `in_ready`=1, `out_valid`=0, `out_ctrl`=0, `occupancy`=0;
  - `out_data` is undefined until the first load.
- `rst` asserted mid-stall (S2) clears the block within one edge; in-flight entries are lost.

## Structure

- The shared constants header/package holds per-stage `CTRL_WIDTH`/`DATA_WIDTH` values (e.g. `ID_EX_CTRL_WIDTH`, `ID_EX_DATA_WIDTH`) and the control-bit index constants used to pack and unpack the fields.
- One natural sub-module, `pipe_entry`, is instantiated twice (main, skid). It holds valid/ctrl/data with load, clear-ctrl and hold controls.
- The state (S0/S1/S2) is encoded by the two valid bits. `occupancy` = main.valid + skid.valid.

## Test plan

- Reset then stream: push ctrl 0x001..0x005 with `out_ready`=1 → outputs appear one cycle later, consecutive cycles, in order; `occupancy` stays 1.
- Backpressure:
  - `out_ready`=0 while pushing 0x011, 0x012, 0x013 → 0x011 is in main, 0x012 in skid, `in_ready`=0 from the cycle after 0x012, and 0x013 is held upstream;
  - raising `out_ready` → 0x011, 0x012, 0x013 are delivered in order with no gap.
- Flush in S2 with `in_valid`=1 → next cycle `out_valid`=0, `out_ctrl`=0, `occupancy`=0, `in_ready`=1; the flush-cycle input never appears.
- Flush and reset together with `in_valid`=1 → reset values; data unchanged.
- Random `in_valid`/`out_ready`/`flush` for 10k cycles against a reference queue model:
  - no loss, duplication or reorder except flushed entries;
  - `out_ctrl`==0 whenever `out_valid`=0;
  - `occupancy`≤2.
- Parameter sweep with `CTRL_WIDTH`=1 and `DATA_WIDTH`=1 and 256 → the streaming and flush scenarios pass unchanged.
